// File: rtl/motoro3_ramp_ctrl_if.sv
// rtl/motoro3_ramp_ctrl_if.sv - command handshake and motor drive signal bundle for the ramp controller
interface motoro3_ramp_ctrl_if;
  logic       cmdValid;
  logic       cmdReady;
  logic       cmdRun;
  logic       cmdDir;
  logic [9:0] cmdFreq;
  logic       m3start;
  logic       m3forceStop;
  logic       m3invRotate;
  logic       m3freqINC;
  logic       m3freqDEC;
  logic [9:0] curFreq;
  logic       atSpeed;
  logic       busy;

  // Command source / status observer side
  modport master (
    output cmdValid, cmdRun, cmdDir, cmdFreq,
    input  cmdReady, m3start, m3forceStop, m3invRotate, m3freqINC, m3freqDEC,
    input  curFreq, atSpeed, busy
  );

  // Ramp controller side
  modport slave (
    input  cmdValid, cmdRun, cmdDir, cmdFreq,
    output cmdReady, m3start, m3forceStop, m3invRotate, m3freqINC, m3freqDEC,
    output curFreq, atSpeed, busy
  );
endinterface

// File: rtl/motoro3_ramp_ctrl.sv
// rtl/motoro3_ramp_ctrl.sv - stepper frequency ramp controller with brake and direction reversal
module motoro3_ramp_ctrl #(
  parameter int RAMP_DIV  = 10000,
  parameter int BRAKE_CYC = 100000,
  parameter int FREQ_MAX  = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  motoro3_ramp_ctrl_if.slave   bus
);
  localparam int RW = (RAMP_DIV  > 1) ? $clog2(RAMP_DIV)  : 1;
  localparam int BW = (BRAKE_CYC > 1) ? $clog2(BRAKE_CYC) : 1;
  localparam logic [RW-1:0] RAMP_LAST  = RW'(RAMP_DIV - 1);
  localparam logic [BW-1:0] BRAKE_LAST = BW'(BRAKE_CYC - 1);
  localparam logic [9:0]    FMAX       = 10'(FREQ_MAX);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ACCEL = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DECEL = 3'd3;
  localparam logic [2:0] S_BRAKE = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [9:0]    cur_q, cur_d, target_q, target_d;
  logic [RW-1:0] ramp_q, ramp_d;
  logic [BW-1:0] brake_q, brake_d;
  logic          dir_q, dir_d, pend_stop_q, pend_stop_d, pend_rev_q, pend_rev_d;
  logic          start_q, start_d, force_q, force_d, inv_q, inv_d;
  logic          inc_q, inc_d, dec_q, dec_d;
  logic          at_speed_q, at_speed_d, busy_q, busy_d, cmd_ready_q, cmd_ready_d;

  logic          accept, is_run, pend, decel_to_one;
  logic [9:0]    cmd_tgt, goal;

  assign accept  = bus.cmdValid && cmd_ready_q;
  assign is_run  = bus.cmdRun && (bus.cmdFreq != 10'd0);
  assign cmd_tgt = (bus.cmdFreq > FMAX) ? FMAX : bus.cmdFreq;
  assign pend    = pend_stop_q || pend_rev_q;

  // Next-state logic: ramp stepping first, then an accepted command overrides target/state
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    target_d     = target_q;
    ramp_d       = ramp_q;
    brake_d      = brake_q;
    dir_d        = dir_q;
    pend_stop_d  = pend_stop_q;
    pend_rev_d   = pend_rev_q;
    start_d      = start_q;
    force_d      = force_q;
    inv_d        = inv_q;
    inc_d        = 1'b0;
    dec_d        = 1'b0;
    decel_to_one = 1'b0;
    goal         = pend ? 10'd1 : target_q;

    case (state_q)
      S_ACCEL, S_DECEL: begin
        if (state_q == S_DECEL && pend && cur_q == 10'd1) begin
          state_d = S_BRAKE;
          force_d = 1'b1;
          brake_d = '0;
        end else if (ramp_q == RAMP_LAST) begin
          ramp_d = '0;
          if (state_q == S_ACCEL) begin
            if (cur_q < FMAX) begin
              inc_d = 1'b1;
              cur_d = cur_q + 10'd1;
            end
            if (cur_d >= goal) state_d = S_RUN;
          end else begin
            if (cur_q > 10'd1) begin
              dec_d = 1'b1;
              cur_d = cur_q - 10'd1;
            end
            if (pend) begin
              if (cur_d == 10'd1) begin
                state_d = S_BRAKE;
                force_d = 1'b1;
                brake_d = '0;
              end
            end else if (cur_d <= goal) begin
              state_d = S_RUN;
            end
          end
        end else begin
          ramp_d = ramp_q + 1'b1;
        end
      end
      S_BRAKE: begin
        if (brake_q == BRAKE_LAST) begin
          force_d = 1'b0;
          ramp_d  = '0;
          if (pend_stop_q) begin
            start_d = 1'b0;
            cur_d   = 10'd0;
            state_d = S_IDLE;
          end else begin
            inv_d   = dir_q;
            state_d = (target_q == 10'd1) ? S_RUN : S_ACCEL;
          end
          pend_stop_d = 1'b0;
          pend_rev_d  = 1'b0;
        end else begin
          brake_d = brake_q + 1'b1;
        end
      end
      default: ;
    endcase

    if (accept) begin
      ramp_d = '0;
      if (state_q == S_IDLE) begin
        if (is_run) begin
          cur_d    = 10'd1;
          start_d  = 1'b1;
          inv_d    = bus.cmdDir;
          dir_d    = bus.cmdDir;
          target_d = cmd_tgt;
          state_d  = (cmd_tgt == 10'd1) ? S_RUN : S_ACCEL;
        end
      end else begin
        force_d = 1'b0;
        if (!is_run) begin
          pend_stop_d  = 1'b1;
          pend_rev_d   = 1'b0;
          decel_to_one = 1'b1;
        end else if (bus.cmdDir != inv_q) begin
          pend_stop_d  = 1'b0;
          pend_rev_d   = 1'b1;
          dir_d        = bus.cmdDir;
          target_d     = cmd_tgt;
          decel_to_one = 1'b1;
        end else begin
          pend_stop_d = 1'b0;
          pend_rev_d  = 1'b0;
          target_d    = cmd_tgt;
          if (cmd_tgt > cur_d)      state_d = S_ACCEL;
          else if (cmd_tgt < cur_d) state_d = S_DECEL;
          else                      state_d = S_RUN;
        end
        if (decel_to_one) begin
          if (cur_d == 10'd1) begin
            state_d = S_BRAKE;
            force_d = 1'b1;
            brake_d = '0;
          end else begin
            state_d = S_DECEL;
          end
        end
      end
    end

    at_speed_d  = (state_d == S_RUN);
    busy_d      = (state_d != S_IDLE);
    cmd_ready_d = (state_d != S_BRAKE);
  end

  // State and registered outputs, asynchronously cleared by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      target_q    <= '0;
      ramp_q      <= '0;
      brake_q     <= '0;
      dir_q       <= 1'b0;
      pend_stop_q <= 1'b0;
      pend_rev_q  <= 1'b0;
      start_q     <= 1'b0;
      force_q     <= 1'b0;
      inv_q       <= 1'b0;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      at_speed_q  <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      target_q    <= target_d;
      ramp_q      <= ramp_d;
      brake_q     <= brake_d;
      dir_q       <= dir_d;
      pend_stop_q <= pend_stop_d;
      pend_rev_q  <= pend_rev_d;
      start_q     <= start_d;
      force_q     <= force_d;
      inv_q       <= inv_d;
      inc_q       <= inc_d;
      dec_q       <= dec_d;
      at_speed_q  <= at_speed_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign bus.cmdReady    = cmd_ready_q;
  assign bus.m3start     = start_q;
  assign bus.m3forceStop = force_q;
  assign bus.m3invRotate = inv_q;
  assign bus.m3freqINC   = inc_q;
  assign bus.m3freqDEC   = dec_q;
  assign bus.curFreq     = cur_q;
  assign bus.atSpeed     = at_speed_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_motoro3_ramp_ctrl.sv
// tb/tb_motoro3_ramp_ctrl.sv - scoreboard bench for the ramp controller
module tb_motoro3_ramp_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  typedef struct {
    int edge_n;
    bit inc;
    int freq;
  } step_t;
  step_t exp_q[$];

  localparam int SIG_AT = 0, SIG_FS = 1;

  motoro3_ramp_ctrl_if bus();

  motoro3_ramp_ctrl #(.RAMP_DIV(4), .BRAKE_CYC(8), .FREQ_MAX(1000)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #50 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sig(input int sel);
    return (sel == SIG_AT) ? int'(bus.atSpeed) : int'(bus.m3forceStop);
  endfunction

  // Step pulse monitor: every pulse must match the oldest expected step
  always @(negedge clk) begin
    if (bus.m3freqINC || bus.m3freqDEC) begin
      step_t e;
      check("inc_dec_exclusive", int'(bus.m3freqINC && bus.m3freqDEC), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_step", edge_cnt, -1);
      end else begin
        e = exp_q.pop_front();
        check("step_edge", edge_cnt, e.edge_n);
        check("step_kind", int'(bus.m3freqINC), int'(e.inc));
        check("step_freq", int'(bus.curFreq), e.freq);
      end
    end
  end

  task automatic send_cmd(input bit run, input bit dir, input int freq, output int acc);
    @(negedge clk);
    check("cmd_ready", int'(bus.cmdReady), 1);
    bus.cmdValid = 1'b1;
    bus.cmdRun   = run;
    bus.cmdDir   = dir;
    bus.cmdFreq  = 10'(freq);
    @(posedge clk);
    #1;
    acc = edge_cnt;
    bus.cmdValid = 1'b0;
  endtask

  task automatic push_steps(input int from_edge, input int n, input bit inc, input int f0);
    for (int i = 1; i <= n; i++) begin
      step_t e;
      e.edge_n = from_edge + 4 * i;
      e.inc    = inc;
      e.freq   = inc ? f0 + i : f0 - i;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_level(input int sel, input bit lvl, input int bound,
                            input string tag, input int exp_edge);
    int n = 0;
    while (sig(sel) != int'(lvl) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, (sig(sel) == int'(lvl)) ? edge_cnt : -1, exp_edge);
  endtask

  task automatic wait_edge(input int target);
    while (edge_cnt < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int acc, acc2;
    bus.cmdValid = 1'b0;
    bus.cmdRun   = 1'b0;
    bus.cmdDir   = 1'b0;
    bus.cmdFreq  = '0;
    #230;
    check("rst_ready", int'(bus.cmdReady), 1);
    check("rst_outs", int'({bus.m3start, bus.m3forceStop, bus.m3invRotate, bus.m3freqINC,
                            bus.m3freqDEC, bus.atSpeed, bus.busy}), 0);
    check("rst_freq", int'(bus.curFreq), 0);
    @(negedge clk);
    rst = 1'b0;

    // Accelerate from idle to 5
    send_cmd(1'b1, 1'b0, 5, acc);
    push_steps(acc, 4, 1'b1, 1);
    check("start_on", int'(bus.m3start), 1);
    check("start_freq", int'(bus.curFreq), 1);
    check("busy_on", int'(bus.busy), 1);
    wait_level(SIG_AT, 1'b1, 100, "at_speed_5", acc + 16);
    check("freq_5", int'(bus.curFreq), 5);

    // Stop from 5: decelerate, brake 8 cycles, back to idle
    send_cmd(1'b1, 1'b0, 0, acc);
    push_steps(acc, 4, 1'b0, 5);
    wait_level(SIG_FS, 1'b1, 100, "brake_start", acc + 16);
    check("brake_ready", int'(bus.cmdReady), 0);
    check("brake_start_lvl", int'(bus.m3start), 1);
    wait_level(SIG_FS, 1'b0, 100, "brake_end", acc + 24);
    check("stop_start", int'(bus.m3start), 0);
    check("stop_freq", int'(bus.curFreq), 0);
    check("stop_busy", int'(bus.busy), 0);

    // Reversal at 3
    send_cmd(1'b1, 1'b0, 3, acc);
    push_steps(acc, 2, 1'b1, 1);
    wait_level(SIG_AT, 1'b1, 100, "at_speed_3", acc + 8);
    send_cmd(1'b1, 1'b1, 3, acc);
    push_steps(acc, 2, 1'b0, 3);
    push_steps(acc + 16, 2, 1'b1, 1);
    wait_level(SIG_FS, 1'b1, 100, "rev_brake_start", acc + 8);
    check("rev_brake_ready", int'(bus.cmdReady), 0);
    check("rev_brake_dir", int'(bus.m3invRotate), 0);
    wait_level(SIG_FS, 1'b0, 100, "rev_brake_end", acc + 16);
    check("rev_dir", int'(bus.m3invRotate), 1);
    check("rev_start", int'(bus.m3start), 1);
    wait_level(SIG_AT, 1'b1, 100, "rev_at_speed", acc + 24);
    check("rev_freq", int'(bus.curFreq), 3);

    // Clamp 1023 to 1000, then freq=0 acts as stop
    send_cmd(1'b1, 1'b1, 1023, acc);
    push_steps(acc, 997, 1'b1, 3);
    check("clamp_accel", int'(bus.atSpeed), 0);
    wait_level(SIG_AT, 1'b1, 5000, "clamp_at_speed", acc + 3988);
    check("clamp_freq", int'(bus.curFreq), 1000);
    send_cmd(1'b1, 1'b1, 0, acc);
    push_steps(acc, 999, 1'b0, 1000);
    wait_level(SIG_FS, 1'b1, 5000, "zero_brake_start", acc + 3996);
    wait_level(SIG_FS, 1'b0, 100, "zero_brake_end", acc + 4004);
    check("zero_idle_busy", int'(bus.busy), 0);
    check("zero_idle_freq", int'(bus.curFreq), 0);

    // Retarget down while accelerating
    send_cmd(1'b1, 1'b0, 10, acc);
    push_steps(acc, 2, 1'b1, 1);
    wait_edge(acc + 9);
    send_cmd(1'b1, 1'b0, 2, acc2);
    push_steps(acc2, 1, 1'b0, 3);
    wait_level(SIG_AT, 1'b1, 100, "retarget_at_speed", acc2 + 4);
    check("retarget_freq", int'(bus.curFreq), 2);

    // Command landing on a step edge keeps that edge's pulse
    send_cmd(1'b1, 1'b0, 6, acc);
    push_steps(acc, 3, 1'b1, 2);
    wait_edge(acc + 3);
    send_cmd(1'b1, 1'b0, 5, acc2);
    check("step_edge_accept", acc2, acc + 4);
    wait_level(SIG_AT, 1'b1, 100, "step_edge_at_speed", acc + 12);
    check("step_edge_freq", int'(bus.curFreq), 5);

    // Asynchronous reset in the middle of a brake
    send_cmd(1'b1, 1'b0, 0, acc);
    push_steps(acc, 4, 1'b0, 5);
    wait_level(SIG_FS, 1'b1, 100, "pre_rst_brake", acc + 16);
    repeat (3) @(negedge clk);
    #20;
    rst = 1'b1;
    #1;
    check("async_rst_outs", int'({bus.m3start, bus.m3forceStop, bus.m3invRotate, bus.m3freqINC,
                                  bus.m3freqDEC, bus.atSpeed, bus.busy}), 0);
    check("async_rst_freq", int'(bus.curFreq), 0);
    check("async_rst_ready", int'(bus.cmdReady), 1);
    @(negedge clk);
    rst = 1'b0;
    send_cmd(1'b1, 1'b0, 2, acc);
    push_steps(acc, 1, 1'b1, 1);
    check("restart_freq", int'(bus.curFreq), 1);
    wait_level(SIG_AT, 1'b1, 100, "restart_at_speed", acc + 4);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
